// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM state type and padding helper for the sort window loader.
package sort_pkg;
  typedef enum logic {FILL, FULL} state_e;
  function automatic logic [63:0] pad_value(input int width);
    return (width >= 64) ? '1 : (64'd1 << width) - 64'd1;
  endfunction
endpackage

// File: rtl/sort_window_loader.sv
// sort_window_loader: gathers serial elements into a parallel window for a sorting network.
// SORT_WINDOW_PAD_EN adds last_i, closing a window early with all-ones padding.
module sort_window_loader
  import sort_pkg::*;
#(
  parameter int NUMBER_WIDTH   = 10,
  parameter int NUMBERS_AMOUNT = 10
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic [NUMBER_WIDTH-1:0]                      data_i,
  input  logic                                         data_valid_i,
`ifdef SORT_WINDOW_PAD_EN
  input  logic                                         last_i,
`endif
  output logic                                         ready_o,
  output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_o,
  output logic                                         data_valid_o,
  input  logic                                         ready_i
);
  localparam int CW = $clog2(NUMBERS_AMOUNT);
  localparam logic [CW-1:0] LAST = CW'(NUMBERS_AMOUNT - 1);
`ifdef SORT_WINDOW_PAD_EN
  localparam logic [63:0] PAD_ALL = pad_value(NUMBER_WIDTH);
`endif
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] fill_q, fill_d, out_q, out_d, win;
  logic valid_q, valid_d;
  logic accept, out_free, done;
  assign accept   = data_valid_i && ready_o;
  assign out_free = !valid_q || ready_i;
  always_comb begin
`ifdef SORT_WINDOW_PAD_EN
    done = accept && (cnt_q == LAST || last_i);
`else
    done = accept && cnt_q == LAST;
`endif
  end
  // Fill buffer with the incoming element merged in, as it would look after this edge.
  always_comb begin
    win = fill_q;
    for (int i = 0; i < NUMBERS_AMOUNT; i++) begin
      if (CW'(i) == cnt_q) win[i] = data_i;
`ifdef SORT_WINDOW_PAD_EN
      else if (last_i && i > int'(cnt_q)) win[i] = PAD_ALL[NUMBER_WIDTH-1:0];
`endif
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= FILL;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == FILL) state_d = (done && !out_free) ? FULL : FILL;
    else state_d = out_free ? FILL : FULL;
  end
  always_comb begin
    ready_o      = state_q == FILL;
    data_o       = out_q;
    data_valid_o = valid_q;
  end
  always_comb begin
    fill_d  = accept ? win : fill_q;
    cnt_d   = accept ? (done ? '0 : cnt_q + 1'b1) : cnt_q;
    out_d   = out_q;
    valid_d = valid_q && !ready_i;
    if (done && out_free) begin
      out_d   = win;
      valid_d = 1'b1;
    end
    if (state_q == FULL && out_free) begin
      out_d   = fill_q;
      valid_d = 1'b1;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      fill_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_sort_window_loader.sv
// tb_sort_window_loader: scoreboard bench for sort_window_loader (N=4, W=8); pad tests need SORT_WINDOW_PAD_EN.
module tb_sort_window_loader;
  logic clk = 0, rst_n = 0;
  logic [7:0] data_i = '0;
  logic data_valid_i = 0, last_i = 0, ready_i = 0;
  logic ready_o, data_valid_o;
  logic [3:0][7:0] data_o;
  int vectors = 0, miscompares = 0, stalls = 0, mcnt = 0;
  logic [7:0] slot [4];
  logic [31:0] sb [$];

  sort_window_loader #(.NUMBER_WIDTH(8), .NUMBERS_AMOUNT(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .data_valid_i(data_valid_i),
`ifdef SORT_WINDOW_PAD_EN
    .last_i(last_i),
`endif
    .ready_o(ready_o), .data_o(data_o), .data_valid_o(data_valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    data_i = d; last_i = l; data_valid_i = 1;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      stalls++; n++;
      @(negedge clk);
    end
    if (!ready_o) chk("ready_timeout", ready_o, 1);
    @(posedge clk); #1;
    data_valid_i = 0; last_i = 0;
    slot[mcnt] = d;
    mcnt++;
    if (mcnt == 4 || l) begin
      for (int i = mcnt; i < 4; i++) slot[i] = 8'hFF;
      sb.push_back({slot[3], slot[2], slot[1], slot[0]});
      mcnt = 0;
      chk("win_valid", data_valid_o, 1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && data_valid_o && ready_i) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else chk("window", data_o, sb.pop_front());
    end
  end

  initial begin
    #12;
    chk("rst_valid", data_valid_o, 0);
    chk("rst_data", data_o, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_ready", ready_o, 1);
    // Back-to-back window with downstream ready.
    ready_i = 1;
    send(8'd8, 0); send(8'd3, 0); send(8'd5, 0); send(8'd1, 0);
    chk("lat_ready", ready_o, 1);
    chk("lat_data", data_o, 32'h01050308);
    @(posedge clk); #1;
    chk("valid_clear", data_valid_o, 0);
    // Backpressure: second window parks in the fill buffer.
    ready_i = 0;
    send(8'd10, 0); send(8'd20, 0); send(8'd30, 0); send(8'd40, 0);
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
    chk("full_ready", ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_data", data_o, 32'h281E140A);
      chk("hold_valid", data_valid_o, 1);
      chk("hold_ready", ready_o, 0);
    end
    ready_i = 1;
    @(posedge clk); #1;
    ready_i = 0;
    chk("second_data", data_o, 32'h04030201);
    chk("second_valid", data_valid_o, 1);
    chk("second_ready", ready_o, 1);
    @(posedge clk); #1;
    ready_i = 1;
    @(posedge clk); #1;
    // Stream of three windows without bubbles.
    stalls = 0;
    for (int i = 0; i < 12; i++) send(8'($urandom_range(0, 255)), 0);
    chk("stream_stalls", stalls, 0);
    repeat (2) @(posedge clk); #1;
    // Reset mid-window discards the partial fill.
    send(8'd99, 0); send(8'd98, 0);
    rst_n = 0;
    #2;
    chk("mid_rst_valid", data_valid_o, 0);
    chk("mid_rst_data", data_o, 0);
    mcnt = 0;
    @(posedge clk); #1 rst_n = 1;
    chk("mid_rst_ready", ready_o, 1);
    send(8'd11, 0); send(8'd22, 0); send(8'd33, 0); send(8'd44, 0);
    chk("post_rst_data", data_o, 32'h2C21160B);
    repeat (2) @(posedge clk); #1;
`ifdef SORT_WINDOW_PAD_EN
    send(8'd7, 0); send(8'd2, 1);
    chk("pad_data", data_o, 32'hFFFF0207);
    send(8'd5, 0); send(8'd6, 0); send(8'd7, 0); send(8'd8, 1);
    chk("pad_full", data_o, 32'h08070605);
    repeat (2) @(posedge clk); #1;
`endif
    repeat (3) @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
